// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file write port.
// Accepts load and ALU results, drains one per cycle, and forwards queued data to decode.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [AW-1:0]              ld_rd,
   input  logic [DW-1:0]              ld_data,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [AW-1:0]              alu_rd,
   input  logic [DW-1:0]              alu_data,
   output logic [AW-1:0]              A3,
   output logic [DW-1:0]              WD,
   output logic                       We,
   input  logic [AW-1:0]              q1_addr,
   output logic                       q1_hit,
   output logic [DW-1:0]              q1_data,
   input  logic [AW-1:0]              q2_addr,
   output logic                       q2_hit,
   output logic [DW-1:0]              q2_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]    rd_mem   [DEPTH];
   logic [DW-1:0]    data_mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    head, tail, alu_slot;
   logic [CW-1:0]    count_r, free;
   logic             ld_push, alu_push, pop;

   assign free      = DEPTH_C - count_r;
   assign ld_ready  = (free != '0);
   // The ALU only loses the last slot to a load that will actually be enqueued.
   assign alu_ready = (free >= CW'(2)) ||
                      ((free == CW'(1)) && !(ld_valid && (ld_rd != '0)));
   assign ld_push   = ld_valid  && ld_ready  && (ld_rd  != '0);
   assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
   assign pop       = (count_r != '0);
   assign alu_slot  = tail + PW'(ld_push);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count_r <= '0;
         vld     <= '0;
      end else begin
         if (pop) begin
            vld[head] <= 1'b0;
            head      <= head + PW'(1);
         end
         if (ld_push)  vld[tail]     <= 1'b1;
         if (alu_push) vld[alu_slot] <= 1'b1;
         tail    <= tail + PW'(ld_push) + PW'(alu_push);
         count_r <= count_r + CW'(ld_push) + CW'(alu_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (ld_push) begin
         rd_mem[tail]   <= ld_rd;
         data_mem[tail] <= ld_data;
      end
      if (alu_push) begin
         rd_mem[alu_slot]   <= alu_rd;
         data_mem[alu_slot] <= alu_data;
      end
   end

   assign We    = pop;
   assign A3    = pop ? rd_mem[head]   : '0;
   assign WD    = pop ? data_mem[head] : '0;
   assign count = count_r;
   assign empty = (count_r == '0);
   assign full  = (count_r == DEPTH_C);

   // Walk oldest to youngest so the last match found is the youngest.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      q1_hit  = 1'b0;
      q1_data = '0;
      q2_hit  = 1'b0;
      q2_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (vld[idx] && (q1_addr != '0) && (rd_mem[idx] == q1_addr)) begin
            q1_hit  = 1'b1;
            q1_data = data_mem[idx];
         end
         if (vld[idx] && (q2_addr != '0) && (rd_mem[idx] == q2_addr)) begin
            q2_hit  = 1'b1;
            q2_data = data_mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed table, wrap run, random run, async reset.
module tb_wb_write_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid, ld_ready, alu_valid, alu_ready;
   logic [4:0]  ld_rd, alu_rd, A3, q1_addr, q2_addr;
   logic [31:0] ld_data, alu_data, WD, q1_data, q2_data;
   logic        We, q1_hit, q2_hit, empty, full;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .A3(A3), .WD(WD), .We(We),
      .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
      .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lv;  logic [4:0] lrd; logic [31:0] ld;
      logic        av;  logic [4:0] ard; logic [31:0] ad;
      logic [4:0]  qa;
      logic        e_lr, e_ar, e_we;
      logic [4:0]  e_a3; logic [31:0] e_wd; logic [2:0] e_cnt;
      logic        e_hit; logic [31:0] e_qd;
   } vec_t;

   typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

   vec_t tbl[12];
   ent_t mq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic idle();
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
   endtask

   function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 0; d = 0;
      if (a != 0)
         foreach (mq[i]) if (mq[i].rd == a) begin h = 1; d = mq[i].d; end
   endfunction

   initial begin
      int unsigned fr;
      logic e_lr, e_ar, e_we, h1, h2;
      logic [4:0]  e_a3;
      logic [31:0] e_wd, d1, d2;

      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        5,  1, 1, 0, 0,  0,            0, 0, 0};
      tbl[1]  = '{0, 0, 0,            0, 0, 0,        5,  1, 1, 1, 5,  32'hDEADBEEF, 1, 1, 32'hDEADBEEF};
      tbl[2]  = '{1, 3, 32'h11,       1, 3, 32'h22,   3,  1, 1, 0, 0,  0,            0, 0, 0};
      tbl[3]  = '{0, 0, 0,            0, 0, 0,        3,  1, 1, 1, 3,  32'h11,       2, 1, 32'h22};
      tbl[4]  = '{1, 7, 32'h70,       1, 8, 32'h80,   3,  1, 1, 1, 3,  32'h22,       1, 1, 32'h22};
      tbl[5]  = '{1, 9, 32'h90,       1, 10, 32'hA0,  8,  1, 1, 1, 7,  32'h70,       2, 1, 32'h80};
      tbl[6]  = '{1, 11, 32'hB0,      1, 12, 32'hC0,  12, 1, 0, 1, 8,  32'h80,       3, 0, 0};
      tbl[7]  = '{1, 0, 32'h33,       1, 12, 32'hC0,  0,  1, 1, 1, 9,  32'h90,       3, 0, 0};
      tbl[8]  = '{0, 0, 0,            1, 0, 32'h55,   11, 1, 1, 1, 10, 32'hA0,       3, 1, 32'hB0};
      tbl[9]  = '{0, 0, 0,            0, 0, 0,        12, 1, 1, 1, 11, 32'hB0,       2, 1, 32'hC0};
      tbl[10] = '{0, 0, 0,            0, 0, 0,        12, 1, 1, 1, 12, 32'hC0,       1, 1, 32'hC0};
      tbl[11] = '{0, 0, 0,            0, 0, 0,        12, 1, 1, 0, 0,  0,            0, 0, 0};

      idle(); q1_addr = 0; q2_addr = 0;
      rst = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_we", We, 0); chk("rst_a3", A3, 0); chk("rst_wd", WD, 0);
      chk("rst_cnt", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
      chk("rst_ldr", ld_ready, 1); chk("rst_alur", alu_ready, 1);
      chk("rst_hit", q1_hit, 0); chk("rst_qd", q1_data, 0);
      rst = 0;

      foreach (tbl[r]) begin
         @(negedge clk);
         ld_valid = tbl[r].lv; ld_rd = tbl[r].lrd; ld_data = tbl[r].ld;
         alu_valid = tbl[r].av; alu_rd = tbl[r].ard; alu_data = tbl[r].ad;
         q1_addr = tbl[r].qa; q2_addr = tbl[r].qa;
         #1;
         chk($sformatf("t%0d_ldr", r), ld_ready, tbl[r].e_lr);
         chk($sformatf("t%0d_alur", r), alu_ready, tbl[r].e_ar);
         chk($sformatf("t%0d_we", r), We, tbl[r].e_we);
         chk($sformatf("t%0d_a3", r), A3, tbl[r].e_a3);
         chk($sformatf("t%0d_wd", r), WD, tbl[r].e_wd);
         chk($sformatf("t%0d_cnt", r), count, tbl[r].e_cnt);
         chk($sformatf("t%0d_empty", r), empty, tbl[r].e_cnt == 0);
         chk($sformatf("t%0d_full", r), full, 0);
         chk($sformatf("t%0d_q1hit", r), q1_hit, tbl[r].e_hit);
         chk($sformatf("t%0d_q1d", r), q1_data, tbl[r].e_qd);
         chk($sformatf("t%0d_q2hit", r), q2_hit, tbl[r].e_hit);
         chk($sformatf("t%0d_q2d", r), q2_data, tbl[r].e_qd);
      end

      // continuous push/drain across pointer wrap
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         idle();
         if (k < 10) begin ld_valid = 1; ld_rd = 5'(k + 1); ld_data = 32'h1000 + k; end
         #1;
         chk($sformatf("w%0d_we", k), We, k > 0);
         chk($sformatf("w%0d_a3", k), A3, (k > 0) ? k : 0);
         chk($sformatf("w%0d_wd", k), WD, (k > 0) ? 32'h1000 + k - 1 : 0);
         chk($sformatf("w%0d_cnt", k), count, (k > 0) ? 1 : 0);
      end
      @(negedge clk); #1;
      chk("w_end_empty", empty, 1);

      // randomized run against a queue model
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         ld_valid  = ($urandom_range(0, 9) < 7);
         ld_rd     = 5'($urandom_range(0, 7));
         ld_data   = $urandom;
         alu_valid = ($urandom_range(0, 9) < 7);
         alu_rd    = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         q1_addr   = 5'($urandom_range(0, 7));
         q2_addr   = 5'($urandom_range(0, 7));
         #1;
         fr   = 4 - mq.size();
         e_lr = (fr >= 1);
         e_ar = (fr >= 2) || (fr == 1 && !(ld_valid && ld_rd != 0));
         e_we = (mq.size() > 0);
         e_a3 = e_we ? mq[0].rd : 0;
         e_wd = e_we ? mq[0].d  : 0;
         model_lookup(q1_addr, h1, d1);
         model_lookup(q2_addr, h2, d2);
         chk("r_ldr", ld_ready, e_lr); chk("r_alur", alu_ready, e_ar);
         chk("r_we", We, e_we); chk("r_a3", A3, e_a3); chk("r_wd", WD, e_wd);
         chk("r_cnt", count, mq.size()); chk("r_empty", empty, mq.size() == 0);
         chk("r_full", full, mq.size() == 4);
         chk("r_q1hit", q1_hit, h1); chk("r_q1d", q1_data, d1);
         chk("r_q2hit", q2_hit, h2); chk("r_q2d", q2_data, d2);
         if (e_we) void'(mq.pop_front());
         if (ld_valid && e_lr && ld_rd != 0) mq.push_back('{ld_rd, ld_data});
         if (alu_valid && e_ar && alu_rd != 0) mq.push_back('{alu_rd, alu_data});
      end

      // async reset with a partly full queue
      @(negedge clk); idle(); rst = 1; #2; rst = 0;
      @(negedge clk);
      ld_valid = 1; ld_rd = 1; ld_data = 32'hA1; alu_valid = 1; alu_rd = 2; alu_data = 32'hA2;
      @(negedge clk);
      ld_valid = 1; ld_rd = 3; ld_data = 32'hA3; alu_valid = 1; alu_rd = 4; alu_data = 32'hA4;
      @(negedge clk);
      idle(); q1_addr = 2;
      #1;
      chk("ar_pre_cnt", count, 3); chk("ar_pre_we", We, 1);
      #2 rst = 1;
      #1;
      chk("ar_we", We, 0); chk("ar_cnt", count, 0); chk("ar_empty", empty, 1);
      chk("ar_a3", A3, 0); chk("ar_hit", q1_hit, 0);
      @(negedge clk); rst = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); q1_addr = 5'(k); #1;
         chk($sformatf("ar_post%0d_we", k), We, 0);
         chk($sformatf("ar_post%0d_hit", k), q1_hit, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
